// File: rtl/odometer_meas_seq.sv
// odometer_meas_seq: trigger-driven stress/settle/measure sequencer for a ring-oscillator aging odometer.
// Counts synchronized ring-oscillator rising edges during the measurement window.
module odometer_meas_seq #(
    parameter int CNT_W = 16,
    parameter int DUR_W = 20
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             meas_trig_i,
    input  logic             abort_i,
    input  logic [1:0]       ring_sel_i,
    input  logic             ac_dc_cfg_i,
    input  logic [DUR_W-1:0] stress_cycles_i,
    input  logic [3:0]       settle_cycles_i,
    input  logic [11:0]      meas_cycles_i,
    input  logic             rosc_stress_i,
    input  logic             rosc_ref_i,
    output logic             sel_inv_o,
    output logic             sel_nand_o,
    output logic             sel_nor_o,
    output logic             start_o,
    output logic             ac_dc_o,
    output logic             en_rosc_o,
    output logic             en_power_rosc_stress_o,
    output logic             meas_stress_o,
    output logic [CNT_W-1:0] cnt_stress_o,
    output logic [CNT_W-1:0] cnt_ref_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);
    typedef enum logic [2:0] {IDLE, STRESS, SETTLE, MEASURE, FIN} state_t;
    state_t state_q, state_d;
    logic [DUR_W-1:0] tmr_q, tmr_d, stress_q, stress_d, st_len;
    logic [3:0] settle_q, settle_d, se_len;
    logic [11:0] meas_q, meas_d, ms_len;
    logic [1:0] ring_q, ring_d;
    logic acdc_q, acdc_d, err_q, err_d, trig_prev_q, trig, legal, edge_s, edge_r;
    logic [2:0] syn_s_q, syn_r_q;
    logic [CNT_W-1:0] cnt_s_q, cnt_s_d, cnt_r_q, cnt_r_d;
    always_comb begin
        trig = state_q == IDLE && meas_trig_i && !trig_prev_q;
        legal = ring_sel_i != 2'd3;
        // in IDLE the phase lengths come straight from the inputs so the first phase can be chosen on the trigger edge
        st_len = state_q == IDLE ? stress_cycles_i : stress_q;
        se_len = state_q == IDLE ? settle_cycles_i : settle_q;
        ms_len = state_q == IDLE ? meas_cycles_i : meas_q;
        edge_s = syn_s_q[1] && !syn_s_q[2];
        edge_r = syn_r_q[1] && !syn_r_q[2];
        state_d = state_q;
        tmr_d = tmr_q - DUR_W'(1);
        stress_d = stress_q;
        settle_d = settle_q;
        meas_d = meas_q;
        ring_d = ring_q;
        acdc_d = acdc_q;
        err_d = err_q;
        cnt_s_d = (state_q == MEASURE && edge_s && !(&cnt_s_q)) ? cnt_s_q + CNT_W'(1) : cnt_s_q;
        cnt_r_d = (state_q == MEASURE && edge_r && !(&cnt_r_q)) ? cnt_r_q + CNT_W'(1) : cnt_r_q;
        if (abort_i) begin
            state_d = IDLE;
            cnt_s_d = '0;
            cnt_r_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trig && legal) begin
                        state_d = st_len != '0 ? STRESS : se_len != '0 ? SETTLE : ms_len != '0 ? MEASURE : FIN;
                        stress_d = stress_cycles_i;
                        settle_d = settle_cycles_i;
                        meas_d = meas_cycles_i;
                        ring_d = ring_sel_i;
                        acdc_d = ac_dc_cfg_i;
                        err_d = 1'b0;
                        cnt_s_d = '0;
                        cnt_r_d = '0;
                    end else if (trig) begin
                        err_d = 1'b1;
                    end
                end
                STRESS:  state_d = tmr_q != '0 ? STRESS : se_len != '0 ? SETTLE : ms_len != '0 ? MEASURE : FIN;
                SETTLE:  state_d = tmr_q != '0 ? SETTLE : ms_len != '0 ? MEASURE : FIN;
                MEASURE: state_d = tmr_q != '0 ? MEASURE : FIN;
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (state_d != state_q)
            tmr_d = state_d == STRESS ? st_len - DUR_W'(1) :
                    state_d == SETTLE ? DUR_W'(se_len) - DUR_W'(1) : DUR_W'(ms_len) - DUR_W'(1);
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            tmr_q <= '0;
            stress_q <= '0;
            settle_q <= '0;
            meas_q <= '0;
            ring_q <= '0;
            acdc_q <= 1'b0;
            err_q <= 1'b0;
            trig_prev_q <= 1'b0;
            syn_s_q <= '0;
            syn_r_q <= '0;
            cnt_s_q <= '0;
            cnt_r_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q <= tmr_d;
            stress_q <= stress_d;
            settle_q <= settle_d;
            meas_q <= meas_d;
            ring_q <= ring_d;
            acdc_q <= acdc_d;
            err_q <= err_d;
            trig_prev_q <= meas_trig_i;
            syn_s_q <= {syn_s_q[1:0], rosc_stress_i};
            syn_r_q <= {syn_r_q[1:0], rosc_ref_i};
            cnt_s_q <= cnt_s_d;
            cnt_r_q <= cnt_r_d;
        end
    end
    assign busy_o = state_q != IDLE;
    assign done_o = state_q == FIN;
    assign err_o = err_q;
    assign sel_inv_o = busy_o && ring_q == 2'd0;
    assign sel_nand_o = busy_o && ring_q == 2'd1;
    assign sel_nor_o = busy_o && ring_q == 2'd2;
    assign ac_dc_o = busy_o && acdc_q;
    assign start_o = state_q == STRESS || state_q == MEASURE;
    assign en_rosc_o = start_o;
    assign en_power_rosc_stress_o = state_q == STRESS || state_q == SETTLE || state_q == MEASURE;
    assign meas_stress_o = state_q == SETTLE || state_q == MEASURE;
    assign cnt_stress_o = cnt_s_q;
    assign cnt_ref_o = cnt_r_q;
endmodule

// File: doc/odometer_meas_seq.md
ODOMETER_MEAS_SEQ -- requirements
Module: odometer_meas_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of edge counters and CNT_STRESS/CNT_REF.
REQ-002 SHALL have parameter DUR_W, default 20, width of STRESS_CYCLES.
REQ-003 SHALL have a single clock; reset is synchronous and active-high.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 MEAS_TRIG  in  1  run request, rising edge detected.
REQ-007 ABORT  in  1  level, forces return to IDLE.
REQ-008 RING_SEL  in  2  0=INV, 1=NAND, 2=NOR, 3=illegal.
REQ-009 AC_DC_CFG  in  1  stress mode, 1=AC (VCO-clocked), 0=DC.
REQ-010 STRESS_CYCLES  in  DUR_W  stress phase length in CLK cycles.
REQ-011 SETTLE_CYCLES  in  4  settle phase length in CLK cycles.
REQ-012 MEAS_CYCLES  in  12  measurement window length in CLK cycles.
REQ-013 ROSC_STRESS, ROSC_REF  in  1 each  asynchronous ring oscillator outputs.
REQ-014 SEL_INV, SEL_NAND, SEL_NOR  out  1 each  one-hot ring select.
REQ-015 START, AC_DC, EN_ROSC, EN_POWER_ROSC_STRESS, MEAS_STRESS  out  1 each  ring control.
REQ-016 CNT_STRESS, CNT_REF  out  CNT_W each  edge counts of last run.
REQ-017 BUSY  out  1 high in any state but IDLE; DONE  out  1 one-cycle completion pulse; ERR  out  1 sticky illegal-config flag.

Function
REQ-018 States SHALL be IDLE, STRESS, SETTLE, MEASURE, FIN; encoding free.
REQ-019 Trigger SHALL be MEAS_TRIG high with registered previous value low, sampled only in IDLE; ignored elsewhere.
REQ-020 On trigger, RING_SEL, AC_DC_CFG and all three durations SHALL be latched; later input changes affect only the next run.
REQ-021 Trigger with RING_SEL=3 SHALL set ERR, stay in IDLE, leave counts unchanged; ERR clears on the next legal trigger.
REQ-022 Legal trigger SHALL clear CNT_STRESS, CNT_REF and enter STRESS next cycle (or skip phases of zero length, per REQ-023).
REQ-023 STRESS, SETTLE, MEASURE SHALL each last exactly their latched cycle count; a zero count skips that phase entirely.
REQ-024 FIN SHALL last one cycle with DONE=1, then return to IDLE.
REQ-025 Outputs are registered per current state (START/EN_ROSC/EN_POWER_ROSC_STRESS/MEAS_STRESS): IDLE 0/0/0/0, STRESS 1/1/1/0, SETTLE 0/0/1/1, MEASURE 1/1/1/1, FIN 0/0/0/0.
REQ-026 SEL_* SHALL be one-hot from the latched RING_SEL whenever BUSY, all zero in IDLE; AC_DC SHALL equal latched AC_DC_CFG whenever BUSY, 0 in IDLE.
REQ-027 Each ROSC input SHALL pass a 2-flop synchronizer then rising-edge detect; a detected edge increments its counter only while in MEASURE.
REQ-028 Counters SHALL saturate at 2^CNT_W-1, no wrap.
REQ-029 Counts SHALL hold from FIN until the next legal trigger.
REQ-030 ABORT high in any state SHALL return to IDLE next cycle, clear both counts, no DONE pulse; ABORT has priority over trigger and phase completion.
REQ-031 Trigger and ABORT in the same cycle SHALL leave the block in IDLE.

Reset
REQ-032 RESET SHALL, at the next edge, force IDLE and zero every output, counter, latched config, trigger history and synchronizer flop.
REQ-033 RESET mid-run SHALL abort like ABORT, also clearing ERR; RESET dominates all inputs.

Verification
REQ-034 RING_SEL=1, AC_DC_CFG=1, STRESS=10, SETTLE=2, MEAS=64, ROSC_STRESS toggling every 2 CLK, ROSC_REF every 4 -> BUSY 77 cycles, SEL_NAND=1, AC_DC=1, DONE single pulse, CNT_STRESS=16, CNT_REF=8.
REQ-035 STRESS=0, SETTLE=0, MEAS=5 -> trigger enters MEASURE directly, FIN after 5 cycles, START never high without MEAS_STRESS.
REQ-036 ABORT asserted on cycle 3 of STRESS -> IDLE next cycle, counts 0, DONE never asserted, all controls 0.
REQ-037 CNT_W=4, ROSC_STRESS edge every 2 cycles, MEAS=64 -> CNT_STRESS=15 (saturated).
REQ-038 RING_SEL=3 trigger -> ERR=1, BUSY=0; then legal trigger -> ERR=0, run proceeds; MEAS_TRIG held high after run -> no retrigger.
